// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 (CPOL=0, CPHA=0) byte transmitter, MSB first, all timing from clk.
// Define SPI_MASTER_BURST_EN to chain bytes inside one cs window; undefined gives one frame per byte.
module spi_master_tx #(
  parameter int SCK_HALF = 8,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       busy,
  output logic       sck,
  output logic       cs,
  output logic       mosi
);

`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int DIV_W = $clog2(SCK_HALF + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);
  localparam logic [7:0]       GAP_LAST = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  state_t           r_state, w_stateNext;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_gap;
  logic [2:0]       r_bitCnt, w_bitCntNext;
  logic [7:0]       r_shift, w_shiftNext;
  logic             r_sck, w_sckNext;
  logic             r_cs, w_csNext;
  logic             r_done, w_doneNext;
  logic             r_busy, w_busyNext;
  logic             r_armed;
  logic             w_divEnd, w_gapEnd, w_burstSlot, w_accept;

  assign w_divEnd    = (r_div == DIV_LAST);
  assign w_gapEnd    = (r_gap == GAP_LAST);
  assign w_burstSlot = BURST && (r_state == HOLD) && w_divEnd;
  // r_armed keeps tx_ready low until the first edge after reset is released
  assign tx_ready    = r_armed && ((r_state == IDLE) || w_burstSlot);
  assign w_accept    = tx_valid && tx_ready;

  assign sck     = r_sck;
  assign cs      = r_cs;
  assign mosi    = r_shift[7];
  assign tx_done = r_done;
  assign busy    = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:     if (w_accept) w_stateNext = SETUP;
      SETUP:    if (w_divEnd) w_stateNext = SHIFT_HI;
      SHIFT_HI: if (w_divEnd) w_stateNext = (r_bitCnt != 3'd7) ? SHIFT_LO : HOLD;
      SHIFT_LO: if (w_divEnd) w_stateNext = SHIFT_HI;
      HOLD:     if (w_divEnd) w_stateNext = (w_burstSlot && w_accept) ? SETUP : GAP;
      GAP:      if (w_gapEnd) w_stateNext = IDLE;
      default:  w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_sckNext    = r_sck;
    w_csNext     = r_cs;
    w_doneNext   = 1'b0;
    w_busyNext   = r_busy;
    w_shiftNext  = r_shift;
    w_bitCntNext = r_bitCnt;
    unique case (r_state)
      IDLE: if (w_accept) begin
        w_csNext     = 1'b0;
        w_busyNext   = 1'b1;
        w_shiftNext  = tx_data;
        w_bitCntNext = 3'd0;
      end
      SETUP: if (w_divEnd) w_sckNext = 1'b1;
      SHIFT_HI: if (w_divEnd) begin
        w_sckNext = 1'b0;
        if (r_bitCnt != 3'd7) w_shiftNext = {r_shift[6:0], 1'b0};
      end
      SHIFT_LO: if (w_divEnd) begin
        w_sckNext    = 1'b1;
        w_bitCntNext = r_bitCnt + 3'd1;
      end
      HOLD: if (w_divEnd) begin
        w_doneNext = 1'b1;
        // A burst reload keeps cs low and puts the next byte's MSB on mosi
        if (w_burstSlot && w_accept) begin
          w_shiftNext  = tx_data;
          w_bitCntNext = 3'd0;
        end else begin
          w_csNext    = 1'b1;
          w_shiftNext = 8'h00;
        end
      end
      GAP: if (w_gapEnd) w_busyNext = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_gap    <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_sck    <= 1'b0;
      r_cs     <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_armed  <= 1'b1;
      if ((w_stateNext != r_state) || (r_state == IDLE) || (r_state == GAP)) r_div <= '0;
      else                                                                 r_div <= r_div + DIV_W'(1);
      if ((r_state == GAP) && (w_stateNext == GAP)) r_gap <= r_gap + 8'd1;
      else                                          r_gap <= 8'd0;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_sck    <= w_sckNext;
      r_cs     <= w_csNext;
      r_done   <= w_doneNext;
      r_busy   <= w_busyNext;
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed bytes are queued as expectations; a monitor decodes the SPI wire
// and checks bytes, frame length, cs gap, busy release and tx_done placement.
module tb_spi_master_tx;
  localparam int H     = 4;
  localparam int G     = 4;
  localparam int LIMIT = 3000;
`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, busy, sck, cs, mosi;

  always #5 clk = ~clk;

  spi_master_tx #(.SCK_HALF(H), .CS_GAP(G)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done), .busy(busy),
    .sck(sck), .cs(cs), .mosi(mosi)
  );

  int compared = 0;
  int mismatched = 0;
  logic [7:0] expQ[$];
  int frameCnt = 0, doneCnt = 0, riseCnt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Monitor: samples on the falling clk edge, well away from DUT updates
  logic prevSck = 1'b0, prevCs = 1'b1, prevMosi = 1'b0, prevBusy = 1'b0;
  int bitIdx = 0, lowCnt = 0, highCnt = 0, sinceRise = 0, frameBytes = 0;
  bit aborted = 1'b0, haveFrame = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic [7:0] expByte;

  always @(negedge clk) begin
    if (reset) begin
      bitIdx = 0;
      aborted = 1'b1;
      haveFrame = 1'b0;
    end else begin
      if (tx_done) doneCnt++;
      if (mosi !== prevMosi)
        checkOutput("mosiChangeAtLegalEdge", int'((prevSck && !sck) || (cs != prevCs) || tx_done), 1);
      if (!cs && prevCs) begin
        if (haveFrame) checkOutput("csHighGap", (highCnt >= G + 1) ? G + 1 : highCnt, G + 1);
        lowCnt = 1; frameBytes = 0; bitIdx = 0; aborted = 1'b0;
      end else if (!cs) lowCnt++;
      if (cs && !prevCs) begin
        checkOutput("doneAtCsRise", int'(tx_done), 1);
        if (!aborted) checkOutput("frameLength", lowCnt, 17 * H * frameBytes);
        frameCnt++; haveFrame = 1'b1; highCnt = 1; sinceRise = 0; bitIdx = 0;
      end else begin
        if (cs) highCnt++;
        sinceRise++;
      end
      if (!busy && prevBusy) checkOutput("busyFallAfterCsRise", sinceRise, G);
      if (!cs && sck && !prevSck) begin
        riseCnt++;
        rxByte = {rxByte[6:0], mosi};
        bitIdx++;
        if (bitIdx == 8) begin
          bitIdx = 0;
          frameBytes++;
          if (expQ.size() == 0) checkOutput("unexpectedByte", int'(rxByte), -1);
          else begin
            expByte = expQ.pop_front();
            checkOutput("rxByte", int'(rxByte), int'(expByte));
          end
        end
      end
    end
    prevSck = sck; prevCs = cs; prevMosi = mosi; prevBusy = busy;
  end

  // Offers a byte, waits for acceptance; expected bytes go into the scoreboard
  task automatic applyStimulus(input logic [7:0] d, input bit keepValid, input bit expectIt);
    int guard = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    if (expectIt) expQ.push_back(d);
    while (!tx_ready && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("readyWithinBudget", int'(guard < LIMIT), 1);
    @(posedge clk);
    #1;
    if (!keepValid) tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((busy || !tx_ready) && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idleWithinBudget", int'(guard < LIMIT), 1);
    repeat (2) @(negedge clk);
  endtask

  int f0, d0, r0, rises, guard;
  logic prevS;

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetCs", int'(cs), 1);
    checkOutput("resetSck", int'(sck), 0);
    checkOutput("resetMosi", int'(mosi), 0);
    checkOutput("resetReady", int'(tx_ready), 0);
    checkOutput("resetBusy", int'(busy), 0);
    reset = 1'b0;
    #1 checkOutput("readyLowAtRelease", int'(tx_ready), 0);
    @(posedge clk);
    #1 checkOutput("readyRiseAfterRelease", int'(tx_ready), 1);
    repeat (20) @(negedge clk);
    checkOutput("idleCs", int'(cs), 1);
    checkOutput("idleSck", int'(sck), 0);
    checkOutput("idleMosi", int'(mosi), 0);
    checkOutput("idleNoDone", doneCnt, 0);

    $display("[TB] single byte 0xA5");
    f0 = frameCnt; d0 = doneCnt; r0 = riseCnt;
    applyStimulus(8'hA5, 1'b0, 1'b1);
    waitIdle();
    checkOutput("a5Frames", frameCnt - f0, 1);
    checkOutput("a5DonePulses", doneCnt - d0, 1);
    checkOutput("a5SckRises", riseCnt - r0, 8);

    $display("[TB] tx_valid held: 0x00 0xFF 0x3C");
    f0 = frameCnt; d0 = doneCnt;
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b1);
    waitIdle();
    checkOutput("heldFrames", frameCnt - f0, BURST ? 1 : 3);
    checkOutput("heldDonePulses", doneCnt - d0, 3);

    $display("[TB] data change after accept 0xC3");
    applyStimulus(8'hC3, 1'b0, 1'b1);
    tx_data = 8'h00;
    waitIdle();

    $display("[TB] reset mid-frame 0x81");
    d0 = doneCnt;
    applyStimulus(8'h81, 1'b0, 1'b0);
    rises = 0; guard = 0; prevS = sck;
    while (rises < 4 && guard < LIMIT) begin
      @(negedge clk);
      if (sck && !prevS) rises++;
      prevS = sck;
      guard++;
    end
    checkOutput("fourRisesWithinBudget", int'(guard < LIMIT), 1);
    reset = 1'b1;
    #1;
    checkOutput("midResetCs", int'(cs), 1);
    checkOutput("midResetSck", int'(sck), 0);
    checkOutput("midResetMosi", int'(mosi), 0);
    checkOutput("midResetBusy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abortNoDone", doneCnt - d0, 0);
    applyStimulus(8'h81, 1'b0, 1'b1);
    waitIdle();

`ifdef SPI_MASTER_BURST_EN
    $display("[TB] burst 0x12 0x34");
    f0 = frameCnt; d0 = doneCnt; r0 = riseCnt;
    applyStimulus(8'h12, 1'b1, 1'b1);
    applyStimulus(8'h34, 1'b0, 1'b1);
    waitIdle();
    checkOutput("burstFrames", frameCnt - f0, 1);
    checkOutput("burstDonePulses", doneCnt - d0, 2);
    checkOutput("burstSckRises", riseCnt - r0, 16);
`endif

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

SPI mode-0 byte transmitter: accepts bytes over a valid/ready handshake and serialises them MSB-first onto `sck`/`cs`/`mosi`, with all SPI timing derived from the system clock. It is the initiator end of the controller's SPI link. It drives the existing slave receiver in loopback and self-test builds, and pushes colour/config bytes to downstream controllers.

## Interface
- `SCK_HALF`, default 8: `sck` half-period in `clk` cycles; legal range 2..255.
- `CS_GAP`, default 4: minimum `clk` cycles `cs` stays high between frames; legal range 1..255.
- `clk` in 1: system clock; all logic on rising edge. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `tx_valid` in 1: `tx_data` holds a byte to send.
- `tx_data` in 8: byte to send; captured on acceptance.
- `tx_ready` out 1: block can accept a byte this cycle.
- `tx_done` out 1: one-cycle pulse when a frame ends (`cs` rises).
- `busy` out 1: high from acceptance until return to IDLE.
- `sck` out 1: SPI clock, idle low (CPOL=0).
- `cs` out 1: chip select, active low.
- `mosi` out 1: serial data, MSB first, valid around `sck` rising edge (CPHA=0).

## Operation
- All outputs are registered except `tx_ready`.
- Reset values while `reset` is high: `sck`=0, `cs`=1, `mosi`=0, `tx_ready`=0, `tx_done`=0, `busy`=0.
  - Counters and shift register clear.
  - State = IDLE.
  - `tx_ready` rises on the first `clk` edge after `reset` falls.
- Acceptance: `tx_valid && tx_ready` at a rising edge. `tx_data` loads into an 8-bit shift register. Later changes on `tx_data` are ignored.
- States:
  - IDLE: `tx_ready`=1, `cs`=1, `sck`=0. On acceptance → SETUP; on that same edge `cs`←0, `mosi`←`tx_data[7]`, `busy`←1.
  - SETUP: `sck` low for `SCK_HALF` cycles → SHIFT_HI.
  - SHIFT_HI: `sck`=1 for `SCK_HALF` cycles. At the end, `sck`←0.
    - If bit count < 7: shift, `mosi`←next bit, → SHIFT_LO.
    - Otherwise → HOLD; `mosi` holds bit 0.
  - SHIFT_LO: `sck`=0 for `SCK_HALF` cycles → SHIFT_HI; bit count +1.
  - HOLD: `sck`=0, `cs`=0 for `SCK_HALF` cycles. At the end, `cs`←1, `tx_done`←1 for one cycle, `mosi`←0 → GAP.
  - GAP: `cs`=1 for `CS_GAP` cycles. At the end, `busy`←0 → IDLE. `tx_valid` is ignored in GAP.
- Counters:
  - Divider counter is `$clog2(SCK_HALF+1)` bits wide, counts 0..`SCK_HALF`-1, and wraps to 0 on every state transition.
  - Bit counter is 3 bits wide, counts 0..7, no wrap beyond 7.
- Reset mid-frame: outputs return to reset values at once and the byte is dropped. No `tx_done` is issued.
- `tx_valid` held high continuously: back-to-back frames, each separated by `CS_GAP` cycles of IDLE/GAP with `cs` high.

## Timing
- Acceptance edge to first `sck` rise: `SCK_HALF` cycles.
- Frame length (`cs` low): 17×`SCK_HALF` cycles (SETUP + 8 high phases + 7 low phases + HOLD).
- Throughput without burst: one byte per 17×`SCK_HALF` + `CS_GAP` + 1 cycles; the +1 is the IDLE acceptance cycle.
- `mosi` changes only on `sck` falling edges or on a `cs` edge. It is stable for ≥`SCK_HALF` cycles either side of every `sck` rise.
- `tx_done` is asserted in the first cycle `cs` is high.

## Configuration
- `SPI_MASTER_BURST_EN` defined:
  - In the last cycle of HOLD, `tx_ready`=1.
  - If a byte is accepted there: `cs` stays low, `mosi`←new bit 7, the shift register reloads, the next state is SETUP, and `tx_done` pulses once for the completed byte. No GAP is inserted.
  - Burst bytes are separated by 2×`SCK_HALF` cycles of `sck` low.
- `SPI_MASTER_BURST_EN` undefined:
  - `tx_ready` is high only in IDLE.
  - Every byte is framed by its own `cs` low pulse.

## Test plan
- Reset release, then idle 20 cycles → `cs`=1, `sck`=0, `mosi`=0, `tx_ready` rises 1 cycle after release, `tx_done` never pulses.
- `SCK_HALF`=4, send 0xA5 → `cs` low 68 cycles, 8 `sck` rises, sampled bits 1,0,1,0,0,1,0,1, one `tx_done` pulse, `busy` low `CS_GAP` cycles after `cs` rises.
- `tx_valid` held high with bytes 0x00, 0xFF, 0x3C (burst off) → three separate `cs` frames, `cs` high ≥`CS_GAP` cycles between frames, decoded bytes match in order.
- `tx_data` changed to 0x00 the cycle after accepting 0xC3 → wire carries 0xC3.
- Assert `reset` after the 4th `sck` rise of 0x81 → within the same cycle `cs`=1, `sck`=0, `mosi`=0. After release, 0x81 resent in full decodes correctly.
- `SPI_MASTER_BURST_EN` defined, send 0x12, 0x34 back-to-back → single `cs` low window, 16 `sck` rises, two `tx_done` pulses, decoded 0x12 then 0x34.
